// File: rtl/addsub_pkg.sv
// Shared types and opcode encodings for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit ripple slice; also exposes the carry into its MSB so the
// top level can form signed overflow on the final digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin_d,
  output logic [DIGIT-1:0] s_d,
  output logic             cout_d,
  output logic             c_msb
);

  logic [DIGIT-1:0] w_low;
  logic             w_a_msb;
  logic             w_b_msb;

  // Low DIGIT-1 bits summed with one spare bit that catches the carry into the MSB.
  assign w_low   = {1'b0, a_d[DIGIT-2:0]} + {1'b0, b_d[DIGIT-2:0]}
                 + {{(DIGIT-1){1'b0}}, cin_d};
  assign c_msb   = w_low[DIGIT-1];
  assign w_a_msb = a_d[DIGIT-1];
  assign w_b_msb = b_d[DIGIT-1];
  assign s_d     = {w_a_msb ^ w_b_msb ^ c_msb, w_low[DIGIT-2:0]};
  assign cout_d  = (w_a_msb & w_b_msb) | (w_a_msb & c_msb) | (w_b_msb & c_msb);

endmodule

// File: rtl/addsub16_serial.sv
// Multi-cycle adder/subtractor: one DIGIT-wide slice per clock, low digit
// first, operands and result exchanged over valid/ready handshakes.
module addsub16_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_op;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT-1:0]   w_a_d;
  logic [DIGIT-1:0]   w_b_d;
  logic [DIGIT-1:0]   w_s_d;
  logic               w_cout_d;
  logic               w_c_msb;
  logic               w_last;

  assign w_a_d  = r_op_a[r_idx*DIGIT +: DIGIT];
  assign w_b_d  = r_op_b[r_idx*DIGIT +: DIGIT];
  assign w_last = (r_idx == IDX_W'(STEPS-1));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d    (w_a_d),
    .b_d    (w_b_d),
    .cin_d  (r_carry),
    .s_d    (w_s_d),
    .cout_d (w_cout_d),
    .c_msb  (w_c_msb)
  );

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op    <= OP_ADD;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in is inverted into a carry-in.
            r_op_a  <= a;
            r_op_b  <= (op == OP_SUB) ? ~b : b;
            r_carry <= (op == OP_SUB) ? ~cin : cin;
            r_op    <= op;
            r_s     <= '0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_s[r_idx*DIGIT +: DIGIT] <= w_s_d;
          r_carry <= w_cout_d;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= (r_op == OP_ADD) ? w_cout_d : ~w_cout_d;
            r_ovf  <= w_c_msb ^ w_cout_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_addsub16_serial.sv
// Directed-vector bench for addsub16_serial with a queue-based scoreboard
// popped by an independent output monitor.
module tb_addsub16_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        op;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        done_valid;
  logic        done_ready;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  addsub16_serial dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .op          (op),
    .s           (s),
    .cout        (cout),
    .ovf         (ovf),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed on any edge where valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && done_valid && done_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_s",    {16'd0, s}, {16'd0, e.s});
        check("result_cout", {31'd0, cout}, {31'd0, e.cout});
        check("result_ovf",  {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (start_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("start_ready_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation, verify RUN shows start_ready=0 and done_valid rises STEPS edges later.
  task automatic issue(input vec_t v, input bit expect_result);
    int k;
    wait_ready();
    start_valid = 1'b1;
    op  = v.op;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    if (expect_result) sb_q.push_back('{s: v.s, cout: v.cout, ovf: v.ovf});
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 16'hxxxx; b = 16'hxxxx; cin = 1'bx; op = 1'bx;
    check("run_start_ready", {31'd0, start_ready}, 32'd0);
    k = 0;
    while (done_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 32'd4);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (done_valid !== 1'b0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    // op, a, b, cin, s, cout, ovf
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};

    reset = 1'b1; start_valid = 1'b1; done_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start_valid = 1'b0;
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_done_valid",  {31'd0, done_valid}, 32'd0);
    check("rst_s",           {16'd0, s}, 32'd0);
    check("rst_cout",        {31'd0, cout}, 32'd0);
    check("rst_ovf",         {31'd0, ovf}, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1);
      wait_idle();
    end

    // Backpressure: result held while a new request waits at the input.
    done_ready = 1'b0;
    issue('{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0}, 1'b1);
    start_valid = 1'b1; op = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_done_valid",  {31'd0, done_valid}, 32'd1);
      check("bp_start_ready", {31'd0, start_ready}, 32'd0);
      check("bp_s",           {16'd0, s}, 32'h3333);
      check("bp_cout",        {31'd0, cout}, 32'd0);
      check("bp_ovf",         {31'd0, ovf}, 32'd0);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'd0, start_ready}, 32'd1);
    check("bp_release_valid", {31'd0, done_valid}, 32'd0);
    start_valid = 1'b0;
    issue('{1'b0, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0}, 1'b1);
    wait_idle();

    // Leave cout/ovf set, then abort an operation with reset on its second RUN edge.
    issue(vecs[4], 1'b1);
    wait_idle();
    wait_ready();
    start_valid = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_start_ready", {31'd0, start_ready}, 32'd1);
    check("abort_done_valid",  {31'd0, done_valid}, 32'd0);
    check("abort_s",           {16'd0, s}, 32'd0);
    check("abort_cout",        {31'd0, cout}, 32'd0);
    check("abort_ovf",         {31'd0, ovf}, 32'd0);
    issue('{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0}, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
